// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the TX engine and, later, the RX path.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } uart_tx_state_t;

    typedef enum logic [1:0] {
        DB5,
        DB6,
        DB7,
        DB8
    } uart_data_bits_t;

    function automatic logic [3:0] uart_nbits(input uart_data_bits_t db);
        return 4'd5 + {2'b00, db};
    endfunction

    // Keeps only the low N bits of a FIFO word so parity ignores the unused upper bits.
    function automatic logic [7:0] uart_data_mask(input uart_data_bits_t db);
        return 8'hFF >> (2'd3 - db);
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period down-counter: load with clocks-per-bit minus 1, tick while the count sits at zero.
module uart_baud_cnt #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tick
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit serializer fed by a first-word-fall-through FIFO.
// Words flagged with a stored parity error are popped and dropped instead of sent.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int FIFO_DW    = 8,
    parameter int BAUD_DIV_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_tx_en,
    input  logic [BAUD_DIV_W-1:0] i_baud_div,
    input  logic [1:0]            i_data_bits,
    input  logic                  i_parity_en,
    input  logic                  i_parity_odd,
    input  logic                  i_stop2,
    input  logic                  i_fifo_valid,
    input  logic [FIFO_DW-1:0]    i_fifo_data,
    input  logic                  i_fifo_perr,
    output logic                  o_fifo_rd_req,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_drop
);

    uart_tx_state_t        state_q, state_d;
    logic [7:0]            shift_q, shift_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic [2:0]            nm1_q, nm1_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  stop2_q, stop2_d;
    logic [BAUD_DIV_W-1:0] div_q, div_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  drop_q, drop_d;

    logic                  launch_ok;
    logic                  pop;
    logic                  baud_load;
    logic                  baud_tick;
    logic [BAUD_DIV_W-1:0] baud_val;
    uart_data_bits_t       db_in;
    logic [7:0]            word_in;

    assign db_in     = uart_data_bits_t'(i_data_bits);
    assign word_in   = i_fifo_data[7:0] & uart_data_mask(db_in);
    assign launch_ok = i_tx_en & i_fifo_valid & ~i_rst;
    // At launch the divider register is not yet updated, so load straight from the input.
    assign baud_val  = pop ? i_baud_div : div_q;

    uart_baud_cnt #(
        .W(BAUD_DIV_W)
    ) u_baud_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (baud_load),
        .i_load_val (baud_val),
        .o_tick     (baud_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        nm1_d      = nm1_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        div_d      = div_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        drop_d     = 1'b0;
        pop        = 1'b0;
        baud_load  = 1'b0;

        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (launch_ok) begin
                    pop = 1'b1;
                end
            end
            TX_START: begin
                if (baud_tick) begin
                    state_d   = TX_DATA;
                    tx_d      = shift_q[0];
                    bit_cnt_d = nm1_q;
                    baud_load = 1'b1;
                end
            end
            TX_DATA: begin
                if (baud_tick) begin
                    baud_load = 1'b1;
                    if (bit_cnt_q == 3'd0) begin
                        if (par_en_q) begin
                            state_d = TX_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d    = TX_STOP;
                            tx_d       = 1'b1;
                            stop_cnt_d = stop2_q;
                        end
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end
            end
            TX_PARITY: begin
                if (baud_tick) begin
                    state_d    = TX_STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = stop2_q;
                    baud_load  = 1'b1;
                end
            end
            TX_STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q) begin
                        stop_cnt_d = 1'b0;
                        baud_load  = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = TX_IDLE;
                        tx_d    = 1'b1;
                        if (launch_ok) begin
                            pop = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Launch overrides the defaults above: capture the word and the whole frame configuration.
        if (pop) begin
            shift_d   = word_in;
            nm1_d     = 3'(uart_nbits(db_in) - 4'd1);
            par_en_d  = i_parity_en;
            par_bit_d = (^word_in) ^ i_parity_odd;
            stop2_d   = i_stop2;
            div_d     = i_baud_div;
            if (i_fifo_perr) begin
                state_d = TX_IDLE;
                drop_d  = 1'b1;
                tx_d    = 1'b1;
            end else begin
                state_d   = TX_START;
                tx_d      = 1'b0;
                baud_load = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= TX_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            nm1_q      <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            div_q      <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            nm1_q      <= nm1_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            div_q      <= div_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
        end
    end

    assign o_fifo_rd_req = pop;
    assign o_tx          = tx_q;
    assign o_busy        = (state_q != TX_IDLE);
    assign o_done        = done_q;
    assign o_drop        = drop_q;

endmodule
